burst_mem_responder: RTL and testbench

- Responder end of the 64-bit, 4-beat physical-memory burst protocol that the cacheline adaptor drives on `pmem_*`.
- Holds a line-addressed on-chip array and serves whole-line reads and writes as bursts, with a fixed programmable access latency.
- Used as the synthesizable memory behind the mp2 top for FPGA bring-up, and as the bench memory model.

---
 rtl/burst_mem_types.sv | 21 ++
 rtl/burst_mem_array.sv | 35 +++
 rtl/burst_mem_responder.sv | 134 +++++++++++++
 tb/tb_burst_mem_responder.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/burst_mem_types.sv
// Shared types and sizing constants for the burst memory responder.
package burst_mem_types;

    localparam int BURST_LEN        = 4;
    localparam int BEAT_WIDTH       = 64;
    localparam int LINE_OFFSET_BITS = 5;
    localparam int BEAT_SEL_BITS    = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        BURST = 2'd2,
        DONE  = 2'd3
    } state_e;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_e;

endpackage

// File: rtl/burst_mem_array.sv
// Line-organised storage: 2**INDEX_BITS lines of BURST_LEN 64-bit beats.
// Single port, synchronous write, registered read (read-during-write
// returns the old contents). No reset: contents survive a responder reset.
module burst_mem_array
    import burst_mem_types::*;
#(
    parameter int INDEX_BITS = 6
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [INDEX_BITS-1:0]    index_i,
    input  logic [BEAT_SEL_BITS-1:0] beat_i,
    input  logic [BEAT_WIDTH-1:0]    wdata_i,
    output logic [BEAT_WIDTH-1:0]    rdata_o
);

    localparam int DEPTH = (2 ** INDEX_BITS) * BURST_LEN;

    logic [BEAT_WIDTH-1:0]               mem_q [DEPTH];
    logic [BEAT_WIDTH-1:0]               rdata_q;
    logic [INDEX_BITS+BEAT_SEL_BITS-1:0] addr;

    assign addr = {index_i, beat_i};

    // Single-port access: optional write plus registered read of the same word.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr] <= wdata_i;
        end
        rdata_q <= mem_q[addr];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/burst_mem_responder.sv
// Responder side of the 4-beat, 64-bit pmem burst protocol, backed by a
// line-addressed on-chip array with a fixed access latency.
//
// state | meaning
// IDLE  | waiting for pmem_read / pmem_write; latches index and op
// WAIT  | latency countdown; last cycle issues the array read of beat 0
// BURST | pmem_resp high, one beat per cycle, beats 0..3
// DONE  | one quiet cycle so the initiator can drop its request
module burst_mem_responder
    import burst_mem_types::*;
#(
    parameter int INDEX_BITS = 6,
    parameter int LATENCY    = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [31:0]           pmem_address,
    input  logic                  pmem_read,
    input  logic                  pmem_write,
    input  logic [BEAT_WIDTH-1:0] pmem_wdata,
    output logic [BEAT_WIDTH-1:0] pmem_rdata,
    output logic                  pmem_resp,
    output logic                  err_o
);

    localparam logic [3:0] LAT_INIT = 4'(LATENCY - 1);

    state_e                   state_q;
    op_e                      op_q;
    logic [INDEX_BITS-1:0]    idx_q;
    logic [3:0]               lat_cnt_q;
    logic [BEAT_SEL_BITS-1:0] beat_q;
    logic                     resp_q;
    logic                     err_q;

    logic                     req_held;
    logic                     arr_we;
    logic [BEAT_SEL_BITS-1:0] arr_beat;
    logic [BEAT_WIDTH-1:0]    arr_rdata;
    logic                     addr_unused;

    // Offset bits and aliased upper bits never select storage.
    assign addr_unused = ^{pmem_address[LINE_OFFSET_BITS-1:0],
                           pmem_address[31:LINE_OFFSET_BITS+INDEX_BITS]};

    // The request line matching the latched op must stay high through the burst.
    assign req_held = (op_q == OP_READ) ? pmem_read : pmem_write;

    // Array port steering: writes target the current beat; reads prefetch the
    // next beat so the registered read lines up with the following BURST cycle.
    always_comb begin
        arr_we   = 1'b0;
        arr_beat = '0;
        if (state_q == BURST) begin
            if (op_q == OP_WRITE) begin
                arr_we   = reset_n;
                arr_beat = beat_q;
            end else begin
                arr_beat = beat_q + 2'd1;
            end
        end
    end

    burst_mem_array #(
        .INDEX_BITS (INDEX_BITS)
    ) u_array (
        .clk     (clk),
        .we_i    (arr_we),
        .index_i (idx_q),
        .beat_i  (arr_beat),
        .wdata_i (pmem_wdata),
        .rdata_o (arr_rdata)
    );

    // Request sequencing, beat counting, registered strobe and sticky error.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            op_q      <= OP_READ;
            idx_q     <= '0;
            lat_cnt_q <= '0;
            beat_q    <= '0;
            resp_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pmem_read || pmem_write) begin
                        state_q   <= WAIT;
                        op_q      <= pmem_read ? OP_READ : OP_WRITE;
                        idx_q     <= pmem_address[LINE_OFFSET_BITS +: INDEX_BITS];
                        lat_cnt_q <= LAT_INIT;
                        if (pmem_read && pmem_write) begin
                            err_q <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (!req_held) begin
                        err_q <= 1'b1;
                    end
                    if (lat_cnt_q == 4'd0) begin
                        state_q <= BURST;
                        beat_q  <= '0;
                        resp_q  <= 1'b1;
                    end else begin
                        lat_cnt_q <= lat_cnt_q - 4'd1;
                    end
                end
                BURST: begin
                    if (!req_held) begin
                        err_q <= 1'b1;
                    end
                    beat_q <= beat_q + 2'd1;
                    if (beat_q == 2'(BURST_LEN - 1)) begin
                        state_q <= DONE;
                        resp_q  <= 1'b0;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign pmem_resp  = resp_q;
    assign pmem_rdata = (resp_q && op_q == OP_READ) ? arr_rdata : '0;
    assign err_o      = err_q;

endmodule

// File: tb/tb_burst_mem_responder.sv
// Directed bench: one responder at LATENCY=4, one at LATENCY=1.
module tb_burst_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n   [2];
    logic        rd_s    [2];
    logic        wr_s    [2];
    logic [31:0] addr_s  [2];
    logic [63:0] wdata_s [2];
    logic [63:0] rdata_o [2];
    logic        resp_o  [2];
    logic        err_s   [2];

    int checks = 0;
    int errors = 0;

    burst_mem_responder #(.INDEX_BITS(6), .LATENCY(4)) u_dut0 (
        .clk          (clk),
        .reset_n      (rst_n[0]),
        .pmem_address (addr_s[0]),
        .pmem_read    (rd_s[0]),
        .pmem_write   (wr_s[0]),
        .pmem_wdata   (wdata_s[0]),
        .pmem_rdata   (rdata_o[0]),
        .pmem_resp    (resp_o[0]),
        .err_o        (err_s[0])
    );

    burst_mem_responder #(.INDEX_BITS(6), .LATENCY(1)) u_dut1 (
        .clk          (clk),
        .reset_n      (rst_n[1]),
        .pmem_address (addr_s[1]),
        .pmem_read    (rd_s[1]),
        .pmem_write   (wr_s[1]),
        .pmem_wdata   (wdata_s[1]),
        .pmem_rdata   (rdata_o[1]),
        .pmem_resp    (resp_o[1]),
        .err_o        (err_s[1])
    );

    localparam logic [255:0] LN0 = {64'h4444444444444444, 64'h3333333333333333,
                                    64'h2222222222222222, 64'h1111111111111111};
    localparam logic [255:0] LNC = {64'hCCCC000000000003, 64'hCCCC000000000002,
                                    64'hCCCC000000000001, 64'hCCCC000000000000};
    localparam logic [255:0] LNA = {64'hAAAA000000000003, 64'hAAAA000000000002,
                                    64'hAAAA000000000001, 64'hAAAA000000000000};
    localparam logic [255:0] LNB = {64'hBBBB000000000003, 64'hBBBB000000000002,
                                    64'hBBBB000000000001, 64'hBBBB000000000000};
    localparam logic [255:0] LBA = {64'hAAAA000000000003, 64'hAAAA000000000002,
                                    64'hBBBB000000000001, 64'hBBBB000000000000};
    localparam logic [255:0] LND = {64'hDDDD000000000003, 64'hDDDD000000000002,
                                    64'hDDDD000000000001, 64'hDDDD000000000000};
    localparam logic [255:0] LNE = {64'hDEADBEEF00000003, 64'hDEADBEEF00000002,
                                    64'hDEADBEEF00000001, 64'hDEADBEEF00000000};

    typedef struct {
        int           s;
        bit           rd;
        bit           wr;
        logic [31:0]  addr;
        logic [255:0] wd;
        logic [255:0] ex;
        bit           chk;
        int           drop;
        int           rstb;
        bit           exp_err;
    } vec_t;

    vec_t vecs [11];

    function automatic int lat_of(input int s);
        return (s == 1) ? 1 : 4;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One whole transaction; the request edge is T and k counts negedges after it.
    task automatic run_txn(input int id, input int s, input bit rd, input bit wr,
                           input logic [31:0] a, input logic [255:0] wd,
                           input logic [255:0] ex, input bit chk_rd,
                           input int drop, input int rstb);
        int  lat;
        int  b;
        bit  exp_resp;
        bit  stop;
        lat  = lat_of(s);
        stop = 1'b0;
        @(negedge clk);
        rd_s[s]   = rd;
        wr_s[s]   = wr;
        addr_s[s] = a;
        @(posedge clk);
        for (int k = 0; k <= lat + 4 && !stop; k++) begin
            @(negedge clk);
            if (k == 0) addr_s[s] = 32'hFFFF_FFE0;
            exp_resp = (k >= lat) && (k <= lat + 3);
            chk($sformatf("v%0d resp k%0d", id, k), {63'b0, resp_o[s]}, {63'b0, exp_resp});
            if (exp_resp) begin
                b = k - lat;
                wdata_s[s] = wd[b*64 +: 64];
                if (chk_rd)
                    chk($sformatf("v%0d rdata beat%0d", id, b), rdata_o[s], ex[b*64 +: 64]);
                if (b == drop) begin
                    rd_s[s] = 1'b0;
                    wr_s[s] = 1'b0;
                end
                if (b == rstb) begin
                    rst_n[s] = 1'b0;
                    @(negedge clk);
                    chk($sformatf("v%0d resp after reset", id), {63'b0, resp_o[s]}, 64'd0);
                    chk($sformatf("v%0d rdata after reset", id), rdata_o[s], 64'd0);
                    rst_n[s] = 1'b1;
                    stop = 1'b1;
                end
            end
            if (k == lat + 4 || stop) begin
                rd_s[s] = 1'b0;
                wr_s[s] = 1'b0;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit exp_resp;
        int b;

        vecs[0]  = '{0, 1'b0, 1'b1, 32'h0000_0040, LN0,  '0, 1'b0, -1, -1, 1'b0};
        vecs[1]  = '{0, 1'b1, 1'b0, 32'h0000_0040, '0,  LN0, 1'b1, -1, -1, 1'b0};
        vecs[2]  = '{0, 1'b0, 1'b1, 32'h0000_0820, LNC,  '0, 1'b0, -1, -1, 1'b0};
        vecs[3]  = '{0, 1'b1, 1'b0, 32'h0000_003F, '0,  LNC, 1'b1, -1, -1, 1'b0};
        vecs[4]  = '{0, 1'b0, 1'b1, 32'h0000_0080, LNA,  '0, 1'b0, -1, -1, 1'b0};
        vecs[5]  = '{0, 1'b1, 1'b0, 32'h0000_0080, '0,  LNA, 1'b1, -1, -1, 1'b0};
        vecs[6]  = '{0, 1'b0, 1'b1, 32'h0000_0080, LNB,  '0, 1'b0, -1,  2, 1'b0};
        vecs[7]  = '{0, 1'b1, 1'b0, 32'h0000_0080, '0,  LBA, 1'b1, -1, -1, 1'b0};
        vecs[8]  = '{0, 1'b1, 1'b1, 32'h0000_0040, LNE, LN0, 1'b1, -1, -1, 1'b1};
        vecs[9]  = '{0, 1'b1, 1'b0, 32'h0000_0040, '0,  LN0, 1'b1, -1, -1, 1'b1};
        vecs[10] = '{1, 1'b1, 1'b0, 32'h0000_0100, '0,  LND, 1'b1,  1, -1, 1'b1};

        for (int s = 0; s < 2; s++) begin
            rst_n[s]   = 1'b0;
            rd_s[s]    = 1'b0;
            wr_s[s]    = 1'b0;
            addr_s[s]  = '0;
            wdata_s[s] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            chk($sformatf("reset resp d%0d", s), {63'b0, resp_o[s]}, 64'd0);
            chk($sformatf("reset rdata d%0d", s), rdata_o[s], 64'd0);
            chk($sformatf("reset err d%0d", s), {63'b0, err_s[s]}, 64'd0);
        end
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;

        // LATENCY=1: fill a line, then two reads with pmem_read held throughout.
        run_txn(100, 1, 1'b0, 1'b1, 32'h0000_0100, LND, '0, 1'b0, -1, -1);
        @(negedge clk);
        rd_s[1]   = 1'b1;
        addr_s[1] = 32'h0000_0100;
        @(posedge clk);
        for (int k = 0; k <= 12; k++) begin
            @(negedge clk);
            exp_resp = (k >= 1 && k <= 4) || (k >= 8 && k <= 11);
            chk($sformatf("b2b resp k%0d", k), {63'b0, resp_o[1]}, {63'b0, exp_resp});
            if (exp_resp) begin
                b = (k <= 4) ? k - 1 : k - 8;
                chk($sformatf("b2b rdata k%0d", k), rdata_o[1], LND[b*64 +: 64]);
            end
            if (k == 12) rd_s[1] = 1'b0;
        end
        chk("b2b err", {63'b0, err_s[1]}, 64'd0);

        for (int i = 0; i < 11; i++) begin
            run_txn(i, vecs[i].s, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wd,
                    vecs[i].ex, vecs[i].chk, vecs[i].drop, vecs[i].rstb);
            chk($sformatf("v%0d err", i), {63'b0, err_s[vecs[i].s]}, {63'b0, vecs[i].exp_err});
        end

        // Sticky error clears only through reset.
        @(negedge clk);
        rst_n[0] = 1'b0;
        @(negedge clk);
        chk("err cleared by reset", {63'b0, err_s[0]}, 64'd0);
        rst_n[0] = 1'b1;
        @(negedge clk);
        chk("err still set d1", {63'b0, err_s[1]}, 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
